// File: rtl/id_ex_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | id_ex_stage : ID/EX pipeline register with load-use hazard detection,    |
// |               redirect/stall handling and a saturating bubble counter.   |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module id_ex_stage #(
   parameter int XLEN  = 64,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic [6:0]       id_opcode,
   input  logic [4:0]       id_aluc,
   input  logic             id_aluOut_WB_memOut,
   input  logic             id_rs1Data_EX_PC,
   input  logic [1:0]       id_rs2Data_EX_imm64_4,
   input  logic             id_write_reg,
   input  logic             id_write_mem,
   input  logic             id_read_mem,
   input  logic [1:0]       id_pcImm_NEXTPC_rs1Imm,
   input  logic [XLEN-1:0]  id_pc,
   input  logic [XLEN-1:0]  id_rs1_data,
   input  logic [XLEN-1:0]  id_rs2_data,
   input  logic [XLEN-1:0]  id_imm64,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic [4:0]       id_rd,
   input  logic             ex_redirect,
   input  logic             mem_stall,
   output logic             ex_valid,
   output logic [4:0]       ex_aluc,
   output logic             ex_aluOut_WB_memOut,
   output logic             ex_rs1Data_EX_PC,
   output logic [1:0]       ex_rs2Data_EX_imm64_4,
   output logic             ex_write_reg,
   output logic             ex_write_mem,
   output logic             ex_read_mem,
   output logic [1:0]       ex_pcImm_NEXTPC_rs1Imm,
   output logic [XLEN-1:0]  ex_pc,
   output logic [XLEN-1:0]  ex_rs1_data,
   output logic [XLEN-1:0]  ex_rs2_data,
   output logic [XLEN-1:0]  ex_imm64,
   output logic [4:0]       ex_rs1,
   output logic [4:0]       ex_rs2,
   output logic [4:0]       ex_rd,
   output logic             hazard_stall,
   output logic [CNT_W-1:0] bubble_cnt
);

   localparam logic [6:0]       c_op_lui    = 7'b0110111;
   localparam logic [6:0]       c_op_auipc  = 7'b0010111;
   localparam logic [6:0]       c_op_jal    = 7'b1101111;
   localparam logic [6:0]       c_op_branch = 7'b1100011;
   localparam logic [6:0]       c_op_store  = 7'b0100011;
   localparam logic [6:0]       c_op_rtype  = 7'b0110011;
   localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);

   logic             valid_q,   valid_d;
   logic [4:0]       aluc_q,    aluc_d;
   logic             wbsel_q,   wbsel_d;
   logic             asel_q,    asel_d;
   logic [1:0]       bsel_q,    bsel_d;
   logic             wreg_q,    wreg_d;
   logic             wmem_q,    wmem_d;
   logic             rmem_q,    rmem_d;
   logic [1:0]       pcsel_q,   pcsel_d;
   logic [XLEN-1:0]  pc_q,      pc_d;
   logic [XLEN-1:0]  rs1_dat_q, rs1_dat_d;
   logic [XLEN-1:0]  rs2_dat_q, rs2_dat_d;
   logic [XLEN-1:0]  imm_q,     imm_d;
   logic [4:0]       rs1_q,     rs1_d;
   logic [4:0]       rs2_q,     rs2_d;
   logic [4:0]       rd_q,      rd_d;
   logic [CNT_W-1:0] cnt_q,     cnt_d;

   logic w_uses_rs1;
   logic w_uses_rs2;
   logic w_load_use;
   logic w_bubble;
   logic w_capture;

   always_comb begin
      w_uses_rs1 = !((id_opcode == c_op_lui) || (id_opcode == c_op_auipc) ||
                     (id_opcode == c_op_jal));
      w_uses_rs2 = (id_opcode == c_op_branch) || (id_opcode == c_op_store) ||
                   (id_opcode == c_op_rtype);
      w_load_use = id_valid && valid_q && rmem_q && (rd_q != 5'd0) &&
                   ((w_uses_rs1 && (id_rs1 == rd_q)) ||
                    (w_uses_rs2 && (id_rs2 == rd_q)));
      // A frozen pipeline or a redirect both mask the hazard so IF is never held
      // for an instruction that is about to be killed or is not moving anyway.
      w_bubble     = !mem_stall && (ex_redirect || w_load_use);
      w_capture    = !mem_stall && !w_bubble;
      hazard_stall = !mem_stall && !ex_redirect && w_load_use;
   end

   always_comb begin
      valid_d   = valid_q;
      aluc_d    = aluc_q;
      wbsel_d   = wbsel_q;
      asel_d    = asel_q;
      bsel_d    = bsel_q;
      wreg_d    = wreg_q;
      wmem_d    = wmem_q;
      rmem_d    = rmem_q;
      pcsel_d   = pcsel_q;
      pc_d      = pc_q;
      rs1_dat_d = rs1_dat_q;
      rs2_dat_d = rs2_dat_q;
      imm_d     = imm_q;
      rs1_d     = rs1_q;
      rs2_d     = rs2_q;
      rd_d      = rd_q;
      cnt_d     = cnt_q;

      if (w_capture) begin
         valid_d   = id_valid;
         aluc_d    = id_aluc;
         wbsel_d   = id_aluOut_WB_memOut;
         asel_d    = id_rs1Data_EX_PC;
         bsel_d    = id_rs2Data_EX_imm64_4;
         wreg_d    = id_write_reg;
         wmem_d    = id_write_mem;
         rmem_d    = id_read_mem;
         pcsel_d   = id_pcImm_NEXTPC_rs1Imm;
         pc_d      = id_pc;
         rs1_dat_d = id_rs1_data;
         rs2_dat_d = id_rs2_data;
         imm_d     = id_imm64;
         rs1_d     = id_rs1;
         rs2_d     = id_rs2;
         rd_d      = id_rd;
      end else if (w_bubble) begin
         // Datapath and index registers are left alone; only control is squashed.
         valid_d = 1'b0;
         aluc_d  = 5'd0;
         wbsel_d = 1'b0;
         asel_d  = 1'b0;
         bsel_d  = 2'd0;
         wreg_d  = 1'b0;
         wmem_d  = 1'b0;
         rmem_d  = 1'b0;
         pcsel_d = 2'd0;
         if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + c_cnt_one;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q   <= 1'b0;
         aluc_q    <= 5'd0;
         wbsel_q   <= 1'b0;
         asel_q    <= 1'b0;
         bsel_q    <= 2'd0;
         wreg_q    <= 1'b0;
         wmem_q    <= 1'b0;
         rmem_q    <= 1'b0;
         pcsel_q   <= 2'd0;
         pc_q      <= '0;
         rs1_dat_q <= '0;
         rs2_dat_q <= '0;
         imm_q     <= '0;
         rs1_q     <= 5'd0;
         rs2_q     <= 5'd0;
         rd_q      <= 5'd0;
         cnt_q     <= '0;
      end else begin
         valid_q   <= valid_d;
         aluc_q    <= aluc_d;
         wbsel_q   <= wbsel_d;
         asel_q    <= asel_d;
         bsel_q    <= bsel_d;
         wreg_q    <= wreg_d;
         wmem_q    <= wmem_d;
         rmem_q    <= rmem_d;
         pcsel_q   <= pcsel_d;
         pc_q      <= pc_d;
         rs1_dat_q <= rs1_dat_d;
         rs2_dat_q <= rs2_dat_d;
         imm_q     <= imm_d;
         rs1_q     <= rs1_d;
         rs2_q     <= rs2_d;
         rd_q      <= rd_d;
         cnt_q     <= cnt_d;
      end
   end

   assign ex_valid               = valid_q;
   assign ex_aluc                = aluc_q;
   assign ex_aluOut_WB_memOut    = wbsel_q;
   assign ex_rs1Data_EX_PC       = asel_q;
   assign ex_rs2Data_EX_imm64_4  = bsel_q;
   assign ex_write_reg           = wreg_q;
   assign ex_write_mem           = wmem_q;
   assign ex_read_mem            = rmem_q;
   assign ex_pcImm_NEXTPC_rs1Imm = pcsel_q;
   assign ex_pc                  = pc_q;
   assign ex_rs1_data            = rs1_dat_q;
   assign ex_rs2_data            = rs2_dat_q;
   assign ex_imm64               = imm_q;
   assign ex_rs1                 = rs1_q;
   assign ex_rs2                 = rs2_q;
   assign ex_rd                  = rd_q;
   assign bubble_cnt             = cnt_q;

endmodule
`default_nettype wire
